nec_ir_tx: RTL and testbench

NEC_IR_TX -- requirements
Module: nec_ir_tx

---
 rtl/nec_ir_pkg.sv | 50 +++++
 rtl/nec_carrier_gen.sv | 44 ++++
 rtl/nec_ir_tx.sv | 229 ++++++++++++++++++++++
 tb/tb_nec_ir_tx.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nec_ir_pkg.sv
// Shared types and constants for the NEC infrared transmitter.
// Optional feature macro: NEC_REPEAT_EN adds the repeat-code states.
package nec_ir_pkg;

   // Width of every unit-count value (largest is the 192-unit frame period)
   localparam int UNITS_W = 8;
   typedef logic [UNITS_W-1:0] units_t;

   // Durations in NEC units
   localparam units_t LEADER_MARK  = 8'd16;
   localparam units_t LEADER_SPACE = 8'd8;
   localparam units_t RPT_SPACE    = 8'd4;
   localparam units_t BIT_MARK     = 8'd1;
   localparam units_t ZERO_SPACE   = 8'd1;
   localparam units_t ONE_SPACE    = 8'd3;
   localparam units_t FRAME_PERIOD = 8'd192;

   // Transmitter states; enum labels carry ST_ so they cannot collide
   // with the same-named duration constants above
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LEADER,
      ST_LSPACE,
      ST_BIT_MARK,
      ST_BIT_SPACE,
      ST_STOP
`ifdef NEC_REPEAT_EN
      ,
      ST_RPT_GAP,
      ST_RPT_LEADER,
      ST_RPT_SPACE,
      ST_RPT_STOP
`endif
   } state_t;

   // True for states in which the LED envelope is on
   function automatic logic is_mark(input state_t s);
      logic m;
      m = 1'b0;
      case (s)
         ST_LEADER, ST_BIT_MARK, ST_STOP: m = 1'b1;
`ifdef NEC_REPEAT_EN
         ST_RPT_LEADER, ST_RPT_STOP:      m = 1'b1;
`endif
         default:                         m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/nec_carrier_gen.sv
// Square-wave carrier for the IR LED. restart re-phases the wave so the
// next cycle starts a fresh high half-period.
module nec_carrier_gen #(
   parameter int CARRIER_HALF = 658
) (
   input  logic clk_50,
   input  logic rst_n,
   input  logic restart,
   output logic carrier
);

   localparam int PH_W = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(CARRIER_HALF - 1);

   logic [PH_W-1:0] phase_q, phase_d;
   logic            car_q, car_d;

   // Phase counter wraps every half-period and flips the carrier level
   always_comb begin
      phase_d = phase_q + 1'b1;
      car_d   = car_q;
      if (restart) begin
         phase_d = '0;
         car_d   = 1'b1;
      end else if (phase_q == PH_LAST) begin
         phase_d = '0;
         car_d   = ~car_q;
      end
   end

   // Carrier state registers
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
         car_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         car_q   <= car_d;
      end
   end

   assign carrier = car_q;

endmodule

// File: rtl/nec_ir_tx.sv
// NEC infrared frame transmitter: leader, 32 data bits (address, ~address,
// command, ~command, LSB first), stop burst, with a modulated LED output.
// Optional feature macro: NEC_REPEAT_EN adds repeat_hold and repeat codes
// spaced one frame period apart.
module nec_ir_tx
   import nec_ir_pkg::*;
#(
   parameter int UNIT_CYCLES  = 28125,
   parameter int CARRIER_HALF = 658
) (
   input  logic       clk_50,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] address,
   input  logic [7:0] command,
`ifdef NEC_REPEAT_EN
   input  logic       repeat_hold,
`endif
   output logic       busy,
   output logic       done,
   output logic       ir_env,
   output logic       ir_tx
);

   localparam int UC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [UC_W-1:0] UC_LAST = UC_W'(UNIT_CYCLES - 1);

   state_t          state_q, state_d;
   logic [UC_W-1:0] unit_cnt_q, unit_cnt_d;     // cycles inside current unit
   units_t          units_left_q, units_left_d; // units left after this one
   logic [4:0]      bit_idx_q, bit_idx_d;
   logic [31:0]     data_q, data_d;
   logic            done_q, done_d;

   logic            unit_end;
   logic            state_end;
   logic            load;
   units_t          load_units;
   logic            carrier;
   logic            carrier_restart;

`ifdef NEC_REPEAT_EN
   // Units completed since the most recent leader began; sizes the gap so
   // that consecutive leaders are exactly one frame period apart
   units_t          elapsed_q, elapsed_d;
   units_t          gap_units;
   assign gap_units = FRAME_PERIOD - elapsed_q - units_t'(1);
`endif

   assign unit_end  = (unit_cnt_q == UC_LAST);
   assign state_end = unit_end && (units_left_q == '0);

   // Next-state, duration loading and bit sequencing
   always_comb begin
      state_d      = state_q;
      unit_cnt_d   = unit_cnt_q;
      units_left_d = units_left_q;
      bit_idx_d    = bit_idx_q;
      data_d       = data_q;
      done_d       = 1'b0;
      load         = 1'b0;
      load_units   = '0;
`ifdef NEC_REPEAT_EN
      elapsed_d    = elapsed_q;
`endif

      // Free-running unit timing while a state is active
      if (state_q != ST_IDLE) begin
         if (unit_end) begin
            unit_cnt_d = '0;
            if (!state_end) units_left_d = units_left_q - units_t'(1);
`ifdef NEC_REPEAT_EN
            elapsed_d = elapsed_q + units_t'(1);
`endif
         end else begin
            unit_cnt_d = unit_cnt_q + 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               data_d     = {~command, command, ~address, address};
               state_d    = ST_LEADER;
               load       = 1'b1;
               load_units = LEADER_MARK;
`ifdef NEC_REPEAT_EN
               elapsed_d  = '0;
`endif
            end
         end
         ST_LEADER: begin
            if (state_end) begin
               state_d    = ST_LSPACE;
               load       = 1'b1;
               load_units = LEADER_SPACE;
            end
         end
         ST_LSPACE: begin
            if (state_end) begin
               state_d    = ST_BIT_MARK;
               bit_idx_d  = '0;
               load       = 1'b1;
               load_units = BIT_MARK;
            end
         end
         ST_BIT_MARK: begin
            if (state_end) begin
               state_d    = ST_BIT_SPACE;
               load       = 1'b1;
               load_units = data_q[bit_idx_q] ? ONE_SPACE : ZERO_SPACE;
            end
         end
         ST_BIT_SPACE: begin
            if (state_end) begin
               load       = 1'b1;
               load_units = BIT_MARK;
               if (bit_idx_q == 5'd31) begin
                  state_d   = ST_STOP;
               end else begin
                  state_d   = ST_BIT_MARK;
                  bit_idx_d = bit_idx_q + 5'd1;
               end
            end
         end
         ST_STOP: begin
            if (state_end) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
`ifdef NEC_REPEAT_EN
               if (repeat_hold) begin
                  state_d    = ST_RPT_GAP;
                  load       = 1'b1;
                  load_units = gap_units;
               end
`endif
            end
         end
`ifdef NEC_REPEAT_EN
         ST_RPT_GAP: begin
            if (state_end) begin
               state_d    = ST_RPT_LEADER;
               load       = 1'b1;
               load_units = LEADER_MARK;
               elapsed_d  = '0;
            end
         end
         ST_RPT_LEADER: begin
            if (state_end) begin
               state_d    = ST_RPT_SPACE;
               load       = 1'b1;
               load_units = RPT_SPACE;
            end
         end
         ST_RPT_SPACE: begin
            if (state_end) begin
               state_d    = ST_RPT_STOP;
               load       = 1'b1;
               load_units = BIT_MARK;
            end
         end
         ST_RPT_STOP: begin
            if (state_end) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
               if (repeat_hold) begin
                  state_d    = ST_RPT_GAP;
                  load       = 1'b1;
                  load_units = gap_units;
               end
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      // Entering a state restarts unit timing with its full duration
      if (load) begin
         unit_cnt_d   = '0;
         units_left_d = load_units - units_t'(1);
      end
   end

   // Control and datapath registers
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         unit_cnt_q   <= '0;
         units_left_q <= '0;
         bit_idx_q    <= '0;
         data_q       <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         unit_cnt_q   <= unit_cnt_d;
         units_left_q <= units_left_d;
         bit_idx_q    <= bit_idx_d;
         data_q       <= data_d;
         done_q       <= done_d;
      end
   end

`ifdef NEC_REPEAT_EN
   // Frame-period tracking register
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) elapsed_q <= '0;
      else        elapsed_q <= elapsed_d;
   end
`endif

   // Every new mark starts the carrier on a fresh high half-period
   assign carrier_restart = is_mark(state_d) && (state_d != state_q);

   nec_carrier_gen #(
      .CARRIER_HALF(CARRIER_HALF)
   ) u_carrier (
      .clk_50 (clk_50),
      .rst_n  (rst_n),
      .restart(carrier_restart),
      .carrier(carrier)
   );

   // Envelope follows state directly so reset clears it without a clock
   assign busy   = (state_q != ST_IDLE);
   assign done   = done_q;
   assign ir_env = is_mark(state_q);
   assign ir_tx  = ir_env & carrier;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Self-checking bench for nec_ir_tx with a waveform-level reference model.
module tb_nec_ir_tx;

   localparam int U  = 10;
   localparam int CH = 2;
   localparam int DONE_AT = 1 + 16*U + 8*U + (16*2*U + 16*4*U) + U;

   logic       clk_50 = 1'b0;
   logic       rst_n  = 1'b0;
   logic       start  = 1'b0;
   logic [7:0] address = 8'h00;
   logic [7:0] command = 8'h00;
`ifdef NEC_REPEAT_EN
   logic       repeat_hold = 1'b0;
`endif
   logic       busy, done, ir_env, ir_tx;

   int checks = 0;
   int errors = 0;

   bit exp_env[$];
   bit exp_tx[$];

   always #5 clk_50 = ~clk_50;

   nec_ir_tx #(.UNIT_CYCLES(U), .CARRIER_HALF(CH)) dut (
      .clk_50 (clk_50),
      .rst_n  (rst_n),
      .start  (start),
      .address(address),
      .command(command),
`ifdef NEC_REPEAT_EN
      .repeat_hold(repeat_hold),
`endif
      .busy   (busy),
      .done   (done),
      .ir_env (ir_env),
      .ir_tx  (ir_tx)
   );

   // Reference: a level held for some units; marks carry a 1,1,0,0.. carrier
   function automatic void push_level(input bit lvl, input int units);
      for (int i = 0; i < units*U; i++) begin
         exp_env.push_back(lvl);
         exp_tx.push_back(lvl && (((i / CH) % 2) == 0));
      end
   endfunction

   function automatic void build_frame(input logic [7:0] a, input logic [7:0] c);
      logic [31:0] w;
      w = {~c, c, ~a, a};
      push_level(1'b1, 16);
      push_level(1'b0, 8);
      for (int b = 0; b < 32; b++) begin
         push_level(1'b1, 1);
         push_level(1'b0, w[b] ? 3 : 1);
      end
      push_level(1'b1, 1);
   endfunction

   task automatic test_reset;
      repeat (3) @(negedge clk_50);
      checks++;
      if ({busy, done, ir_env, ir_tx} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_state: busy/done/env/tx=%b expected 0000", {busy, done, ir_env, ir_tx});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk_50);
   endtask

   task automatic test_frame(input logic [7:0] a, input logic [7:0] c);
      int n, done_at, len;
      bit obs[$];
      int runs[$];
      logic [3:0] exp;
      logic [31:0] w, dec;
      exp_env.delete(); exp_tx.delete();
      build_frame(a, c);
      n = exp_env.size();
      w = {~c, c, ~a, a};
      @(negedge clk_50);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL frame_idle: busy=%b expected 0", busy);
      end
      address = a; command = c; start = 1'b1;
      @(posedge clk_50); #1;
      start = 1'b0; address = 8'($urandom); command = 8'($urandom);
      done_at = 0;
      for (int k = 1; k <= n + 1; k++) begin
         @(negedge clk_50);
         if (k <= n) obs.push_back(ir_env);
         if (done === 1'b1 && done_at == 0) done_at = k;
         exp = (k <= n) ? {1'b1, 1'b0, exp_env[k-1], exp_tx[k-1]} : 4'b0100;
         checks++;
         if ({busy, done, ir_env, ir_tx} !== exp) begin
            errors++;
            $display("FAIL frame a=%h c=%h cycle %0d: busy/done/env/tx=%b expected %b",
                     a, c, k, {busy, done, ir_env, ir_tx}, exp);
         end
      end
      checks++;
      if (done_at != DONE_AT) begin
         errors++;
         $display("FAIL frame_done_cycle: got %0d expected %0d", done_at, DONE_AT);
      end
      // Decode the observed envelope back into the 32-bit payload
      len = 1;
      for (int i = 1; i < n; i++) begin
         if (obs[i] == obs[i-1]) len++;
         else begin runs.push_back(len); len = 1; end
      end
      runs.push_back(len);
      checks++;
      if (runs.size() != 67 || !obs[0] || runs[0] != 16*U || runs[1] != 8*U || runs[66] != U) begin
         errors++;
         $display("FAIL frame_shape: runs=%0d first=%0d second=%0d expected 67/%0d/%0d",
                  runs.size(), runs[0], (runs.size() > 1) ? runs[1] : 0, 16*U, 8*U);
      end else begin
         dec = '0;
         for (int b = 0; b < 32; b++) dec[b] = (runs[3 + 2*b] > 2*U);
         checks++;
         if (dec !== w) begin
            errors++;
            $display("FAIL frame_decode: got %h expected %h", dec, w);
         end
      end
   endtask

   task automatic test_ignore_start;
      logic [7:0] a, c;
      int n, dones;
      logic [3:0] exp;
      a = 8'($urandom); c = 8'($urandom);
      exp_env.delete(); exp_tx.delete();
      build_frame(a, c);
      n = exp_env.size();
      @(negedge clk_50);
      address = a; command = c; start = 1'b1;
      @(posedge clk_50); #1;
      start = 1'b0;
      dones = 0;
      for (int k = 1; k <= n + 20; k++) begin
         @(negedge clk_50);
         if (done === 1'b1) dones++;
         if (k == 499) begin start = 1'b1; address = ~a; command = ~c; end
         if (k == 500) start = 1'b0;
         exp = (k <= n) ? {1'b1, 1'b0, exp_env[k-1], exp_tx[k-1]} :
               (k == n + 1) ? 4'b0100 : 4'b0000;
         checks++;
         if ({busy, done, ir_env, ir_tx} !== exp) begin
            errors++;
            $display("FAIL ignore_start cycle %0d: busy/done/env/tx=%b expected %b",
                     k, {busy, done, ir_env, ir_tx}, exp);
         end
      end
      checks++;
      if (dones != 1) begin
         errors++;
         $display("FAIL ignore_start_dones: got %0d expected 1", dones);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] a1, c1, a2, c2;
      int n1, n2, last, dones;
      logic [3:0] exp;
      a1 = 8'($urandom); c1 = 8'($urandom);
      a2 = 8'($urandom); c2 = 8'($urandom);
      exp_env.delete(); exp_tx.delete();
      build_frame(a1, c1);
      n1 = exp_env.size();
      build_frame(a2, c2);
      n2 = exp_env.size() - n1;
      last = n1 + 1 + n2 + 1;
      @(negedge clk_50);
      address = a1; command = c1; start = 1'b1;
      @(posedge clk_50); #1;
      address = a2; command = c2;
      dones = 0;
      for (int k = 1; k <= last + 5; k++) begin
         @(negedge clk_50);
         if (done === 1'b1) dones++;
         if (k == n1 + 10) start = 1'b0;
         if (k <= n1)              exp = {1'b1, 1'b0, exp_env[k-1], exp_tx[k-1]};
         else if (k == n1 + 1)     exp = 4'b0100;
         else if (k < last)        exp = {1'b1, 1'b0, exp_env[k-2], exp_tx[k-2]};
         else if (k == last)       exp = 4'b0100;
         else                      exp = 4'b0000;
         checks++;
         if ({busy, done, ir_env, ir_tx} !== exp) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: busy/done/env/tx=%b expected %b",
                     k, {busy, done, ir_env, ir_tx}, exp);
         end
      end
      checks++;
      if (dones != 2) begin
         errors++;
         $display("FAIL back_to_back_dones: got %0d expected 2", dones);
      end
   endtask

   task automatic test_mid_frame_reset;
      logic [7:0] a, c;
      int dones;
      logic [3:0] exp;
      a = 8'($urandom); c = 8'($urandom);
      exp_env.delete(); exp_tx.delete();
      build_frame(a, c);
      @(negedge clk_50);
      address = a; command = c; start = 1'b1;
      @(posedge clk_50); #1;
      start = 1'b0;
      for (int k = 1; k <= 1000; k++) begin
         @(negedge clk_50);
         exp = {1'b1, 1'b0, exp_env[k-1], exp_tx[k-1]};
         checks++;
         if ({busy, done, ir_env, ir_tx} !== exp) begin
            errors++;
            $display("FAIL pre_reset cycle %0d: busy/done/env/tx=%b expected %b",
                     k, {busy, done, ir_env, ir_tx}, exp);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, ir_env, ir_tx} !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset: busy/done/env/tx=%b expected 0000", {busy, done, ir_env, ir_tx});
      end
      repeat (3) @(negedge clk_50);
      rst_n = 1'b1;
      dones = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk_50);
         if (done === 1'b1) dones++;
         checks++;
         if ({busy, ir_env, ir_tx} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle cycle %0d: busy/env/tx=%b expected 000",
                     k, {busy, ir_env, ir_tx});
         end
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL post_reset_done: got %0d pulses expected 0", dones);
      end
   endtask

`ifdef NEC_REPEAT_EN
   task automatic test_repeat;
      logic [7:0] a, c;
      int n, dones, len;
      int leaders[$];
      bit obs[$];
      logic [3:0] exp;
      bit exp_done;
      a = 8'($urandom); c = 8'($urandom);
      exp_env.delete(); exp_tx.delete();
      build_frame(a, c);
      push_level(1'b0, 192 - 121);
      for (int r = 0; r < 2; r++) begin
         push_level(1'b1, 16);
         push_level(1'b0, 4);
         push_level(1'b1, 1);
         if (r == 0) push_level(1'b0, 192 - 21);
      end
      n = exp_env.size();
      @(negedge clk_50);
      address = a; command = c; start = 1'b1; repeat_hold = 1'b1;
      @(posedge clk_50); #1;
      start = 1'b0;
      dones = 0;
      for (int k = 1; k <= n + 5; k++) begin
         @(negedge clk_50);
         if (k <= n) obs.push_back(ir_env);
         if (done === 1'b1) dones++;
         if (k == 3000) repeat_hold = 1'b0;
         exp_done = (k == 121*U + 1) || (k == 192*U + 21*U + 1) || (k == n + 1);
         exp = (k <= n) ? {1'b1, exp_done, exp_env[k-1], exp_tx[k-1]} : {1'b0, exp_done, 2'b00};
         checks++;
         if ({busy, done, ir_env, ir_tx} !== exp) begin
            errors++;
            $display("FAIL repeat cycle %0d: busy/done/env/tx=%b expected %b",
                     k, {busy, done, ir_env, ir_tx}, exp);
         end
      end
      for (int i = 0; i < n; i++) begin
         if (obs[i] && (i == 0 || !obs[i-1])) begin
            len = 0;
            while (i + len < n && obs[i+len]) len++;
            if (len >= 16*U) leaders.push_back(i + 1);
         end
      end
      checks++;
      if (leaders.size() != 3 || leaders[0] != 1 || leaders[1] != 1 + 192*U || leaders[2] != 1 + 384*U) begin
         errors++;
         $display("FAIL repeat_leaders: count=%0d first=%0d expected 3 starting 1 spaced %0d",
                  leaders.size(), (leaders.size() > 0) ? leaders[0] : -1, 192*U);
      end
      checks++;
      if (dones != 3) begin
         errors++;
         $display("FAIL repeat_dones: got %0d expected 3", dones);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_frame(8'h00, 8'h45);
      test_frame(8'hFF, 8'h45);
      test_frame(8'($urandom), 8'($urandom));
      test_frame(8'($urandom), 8'($urandom));
      test_ignore_start;
      test_back_to_back;
      test_mid_frame_reset;
      test_frame(8'($urandom), 8'($urandom));
`ifdef NEC_REPEAT_EN
      test_repeat;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
